// File: rtl/win_addr_pkg.sv
// Shared types and width helpers for the window address generator.
// The state type is also exported on dbg_state so checkers can bind to it.
package win_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Bits needed to index 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Width of a linear pixel address for a w x h image.
    function automatic int addr_width(input int w, input int h);
        return clog2_min1(w * h);
    endfunction

endpackage

// File: rtl/win_cnt.sv
// Column/row position counter for one window burst.
// It holds at the final position so a late enable cannot wrap it.
module win_cnt
    import win_addr_pkg::*;
#(
    parameter int WIN_W = 24,
    parameter int WIN_H = 24,
    localparam int CW = clog2_min1(WIN_W),
    localparam int RW = clog2_min1(WIN_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_wrap,
    output logic          done
);

    assign col_wrap = (col == CW'(WIN_W - 1));
    assign done     = col_wrap && (row == RW'(WIN_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en && !done) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/win_addr_gen.sv
// Window address generator: turns an accepted (x, y) origin into a burst of
// row-major pixel addresses, either one pixel or a full WIN_W x WIN_H window.
module win_addr_gen
    import win_addr_pkg::*;
#(
    parameter int IMG_WIDTH  = 41,
    parameter int IMG_HEIGHT = 50,
    parameter int WIN_W      = 24,
    parameter int WIN_H      = 24,
    localparam int W_ADDR = addr_width(IMG_WIDTH, IMG_HEIGHT),
    localparam int XW     = clog2_min1(IMG_WIDTH),
    localparam int YW     = clog2_min1(IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              org_valid,
    output logic              org_ready,
    input  logic [XW-1:0]     org_x,
    input  logic [YW-1:0]     org_y,
    input  logic              org_mode,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [W_ADDR-1:0] addr_data,
    output logic              addr_last,
    output logic              err,
    output state_t            dbg_state
);

    localparam int WC = W_ADDR + 1;
    localparam int CW = clog2_min1(WIN_W);
    localparam int RW = clog2_min1(WIN_H);

    // Both ports use valid/ready: a transfer happens on a rising edge where
    // valid && ready; a producer keeps valid and payload stable until then.

    state_t            state;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic              mode_q;
    logic [W_ADDR-1:0] row_base;
    logic [W_ADDR-1:0] cur;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              col_wrap;
    logic              done;
    logic              cnt_clr;
    logic              cnt_en;

    logic [WC-1:0]     x_ext;
    logic [WC-1:0]     y_ext;
    logic              range_ok;
    logic [W_ADDR-1:0] base;
    logic              next_last;

    assign x_ext = WC'(x_q);
    assign y_ext = WC'(y_q);

    // One extra bit so x + WIN_W cannot wrap before the compare.
    always_comb begin
        range_ok = 1'b0;
        if (mode_q) begin
            range_ok = (x_ext + WC'(WIN_W) <= WC'(IMG_WIDTH)) &&
                       (y_ext + WC'(WIN_H) <= WC'(IMG_HEIGHT));
        end else begin
            range_ok = (x_ext < WC'(IMG_WIDTH)) && (y_ext < WC'(IMG_HEIGHT));
        end
    end

    assign base = W_ADDR'(x_q) + W_ADDR'(y_q) * W_ADDR'(IMG_WIDTH);

    // Whether the beat after the one now being accepted closes the window.
    always_comb begin
        next_last = 1'b0;
        if (col_wrap) begin
            next_last = (WIN_W == 1) && (int'(row) == WIN_H - 2);
        end else begin
            next_last = (int'(col) == WIN_W - 2) && (int'(row) == WIN_H - 1);
        end
    end

    assign cnt_clr = (state == LOAD);
    assign cnt_en  = (state == RUN) && addr_ready;

    win_cnt #(
        .WIN_W (WIN_W),
        .WIN_H (WIN_H)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .col      (col),
        .row      (row),
        .col_wrap (col_wrap),
        .done     (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= 1'b0;
            row_base   <= '0;
            cur        <= '0;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (org_valid) begin
                        x_q    <= org_x;
                        y_q    <= org_y;
                        mode_q <= org_mode;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (!range_ok) begin
                        state <= IDLE;
                    end else begin
                        row_base   <= base;
                        cur        <= base;
                        addr_valid <= 1'b1;
                        addr_last  <= !mode_q || ((WIN_W == 1) && (WIN_H == 1));
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (addr_ready) begin
                        if (!mode_q || done) begin
                            addr_valid <= 1'b0;
                            addr_last  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            if (col_wrap) begin
                                row_base <= row_base + W_ADDR'(IMG_WIDTH);
                                cur      <= row_base + W_ADDR'(IMG_WIDTH);
                            end else begin
                                cur <= cur + W_ADDR'(1);
                            end
                            addr_last <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // err is decoded in LOAD, where addr_valid is always low.
    assign err       = (state == LOAD) && !range_ok;
    assign org_ready = (state == IDLE);
    assign addr_data = cur;
    assign dbg_state = state;

endmodule

// File: tb/tb_win_addr_gen.sv
// Directed bench for win_addr_gen: window/single bursts, range errors,
// backpressure and reset in the middle of a burst.
module tb_win_addr_gen;
    import win_addr_pkg::*;

    localparam int IMG_WIDTH  = 41;
    localparam int IMG_HEIGHT = 50;
    localparam int WIN_W      = 24;
    localparam int WIN_H      = 24;
    localparam int W_ADDR     = addr_width(IMG_WIDTH, IMG_HEIGHT);
    localparam int XW         = clog2_min1(IMG_WIDTH);
    localparam int YW         = clog2_min1(IMG_HEIGHT);

    logic              clk;
    logic              rst;
    logic              org_valid;
    logic              org_ready;
    logic [XW-1:0]     org_x;
    logic [YW-1:0]     org_y;
    logic              org_mode;
    logic              addr_valid;
    logic              addr_ready;
    logic [W_ADDR-1:0] addr_data;
    logic              addr_last;
    logic              err;
    state_t            dbg_state;

    win_addr_gen #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .WIN_W      (WIN_W),
        .WIN_H      (WIN_H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .org_valid  (org_valid),
        .org_ready  (org_ready),
        .org_x      (org_x),
        .org_y      (org_y),
        .org_mode   (org_mode),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_data  (addr_data),
        .addr_last  (addr_last),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // scoreboard
    logic [W_ADDR-1:0] exp_q[$];
    logic [W_ADDR-1:0] got_q[$];
    logic              got_last_q[$];
    int                first_valid_cyc;
    int                err_cnt;
    int                hold_bad;
    int                stall_cnt;
    logic              first_org_ready;
    logic              timed_out;

    task automatic build_exp(input int x, input int y, input bit mode);
        exp_q.delete();
        if (mode) begin
            for (int r = 0; r < WIN_H; r++)
                for (int c = 0; c < WIN_W; c++)
                    exp_q.push_back(W_ADDR'((y + r) * IMG_WIDTH + x + c));
        end else begin
            exp_q.push_back(W_ADDR'(y * IMG_WIDTH + x));
        end
    endtask

    // driver: present an origin for one cycle; returns on the LOAD cycle
    task automatic send_origin(input int x, input int y, input bit mode,
                               output logic ready_seen, output logic load_ready,
                               output logic err_at_load);
        @(negedge clk);
        org_valid  = 1'b1;
        org_x      = XW'(x);
        org_y      = YW'(y);
        org_mode   = mode;
        ready_seen = org_ready;
        @(negedge clk);
        org_valid   = 1'b0;
        load_ready  = org_ready;
        err_at_load = err;
    endtask

    // driver + monitor: drive addr_ready and record accepted beats
    task automatic collect(input int max_beats, input int budget, input bit random_ready);
        logic              prev_stall;
        logic [W_ADDR-1:0] prev_data;
        logic              prev_last;
        got_q.delete();
        got_last_q.delete();
        first_valid_cyc = -1;
        err_cnt         = 0;
        hold_bad        = 0;
        stall_cnt       = 0;
        timed_out       = 1'b1;
        first_org_ready = 1'bx;
        prev_stall      = 1'b0;
        prev_data       = '0;
        prev_last       = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (cyc == 0) first_org_ready = org_ready;
            if (err === 1'b1) err_cnt++;
            if (err === 1'b1 && addr_valid === 1'b1) hold_bad++;
            if (prev_stall && (addr_valid !== 1'b1 || addr_data !== prev_data ||
                               addr_last !== prev_last))
                hold_bad++;
            if (addr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            addr_ready = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            prev_stall = (addr_valid === 1'b1) && !addr_ready;
            prev_data  = addr_data;
            prev_last  = addr_last;
            if (prev_stall) stall_cnt++;
            if (addr_valid === 1'b1 && addr_ready) begin
                got_q.push_back(addr_data);
                got_last_q.push_back(addr_last);
                if (addr_last === 1'b1 || got_q.size() == max_beats) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        org_valid  = 1'b0;
        org_x      = '0;
        org_y      = '0;
        org_mode   = 1'b0;
        addr_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (addr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", addr_valid); end
        n_cmp++; if (addr_data !== '0) begin n_bad++; $display("FAIL reset_data: got %0d expected 0", addr_data); end
        n_cmp++; if (addr_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b expected 0", addr_last); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (org_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", org_ready); end
    endtask

    task automatic test_window_origin();
        logic rs, lr, el;
        build_exp(0, 0, 1'b1);
        send_origin(0, 0, 1'b1, rs, lr, el);
        n_cmp++; if (rs !== 1'b1) begin n_bad++; $display("FAIL win00_accept: org_ready %b expected 1", rs); end
        n_cmp++; if (lr !== 1'b0) begin n_bad++; $display("FAIL win00_load_busy: org_ready %b expected 0", lr); end
        n_cmp++; if (el !== 1'b0) begin n_bad++; $display("FAIL win00_load_err: err %b expected 0", el); end
        collect(-1, 1000, 1'b0);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL win00_timeout: no last beat within budget"); end
        n_cmp++; if (first_valid_cyc !== 0) begin n_bad++; $display("FAIL win00_latency: first beat at %0d expected 0 (2 cycles after accept)", first_valid_cyc); end
        n_cmp++; if (got_q.size() !== 576) begin n_bad++; $display("FAIL win00_count: got %0d expected 576", got_q.size()); end
        n_cmp++; if (got_q[23] !== W_ADDR'(23)) begin n_bad++; $display("FAIL win00_beat23: got %0d expected 23", got_q[23]); end
        n_cmp++; if (got_q[24] !== W_ADDR'(41)) begin n_bad++; $display("FAIL win00_beat24: got %0d expected 41", got_q[24]); end
        n_cmp++; if (got_q[$] !== W_ADDR'(966)) begin n_bad++; $display("FAIL win00_lastaddr: got %0d expected 966", got_q[$]); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL win00_err: got %0d pulses expected 0", err_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL win00_seq[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
        for (int i = 0; i < got_last_q.size(); i++) begin
            n_cmp++;
            if (got_last_q[i] !== (i == exp_q.size() - 1)) begin
                n_bad++; $display("FAIL win00_lastflag[%0d]: got %b expected %b", i, got_last_q[i], (i == exp_q.size() - 1));
            end
        end
        @(negedge clk);
        n_cmp++; if (org_ready !== 1'b1 || addr_valid !== 1'b0) begin n_bad++; $display("FAIL win00_idle_after: org_ready %b addr_valid %b expected 1 0", org_ready, addr_valid); end
    endtask

    task automatic test_window_corner();
        logic rs, lr, el;
        build_exp(17, 26, 1'b1);
        send_origin(17, 26, 1'b1, rs, lr, el);
        collect(-1, 1000, 1'b0);
        n_cmp++; if (got_q.size() !== 576) begin n_bad++; $display("FAIL corner_count: got %0d expected 576", got_q.size()); end
        n_cmp++; if (got_q[0] !== W_ADDR'(1083)) begin n_bad++; $display("FAIL corner_first: got %0d expected 1083", got_q[0]); end
        n_cmp++; if (got_q[24] !== W_ADDR'(1124)) begin n_bad++; $display("FAIL corner_row2: got %0d expected 1124", got_q[24]); end
        n_cmp++; if (got_q[$] !== W_ADDR'(2049) || got_last_q[$] !== 1'b1) begin n_bad++; $display("FAIL corner_last: got %0d/%b expected 2049/1", got_q[$], got_last_q[$]); end
        n_cmp++; if (el !== 1'b0 || err_cnt !== 0) begin n_bad++; $display("FAIL corner_err: load %b later %0d expected 0 0", el, err_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL corner_seq[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_range_err();
        int   xs[3] = '{18, 0, 41};
        int   ys[3] = '{0, 27, 0};
        bit   ms[3] = '{1'b1, 1'b1, 1'b0};
        logic rs, lr, el;
        for (int k = 0; k < 3; k++) begin
            send_origin(xs[k], ys[k], ms[k], rs, lr, el);
            collect(0, 6, 1'b0);
            n_cmp++; if (el !== 1'b1) begin n_bad++; $display("FAIL range%0d_err_load: got %b expected 1", k, el); end
            n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL range%0d_err_once: extra pulses %0d expected 0", k, err_cnt); end
            n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL range%0d_beats: got %0d expected 0", k, got_q.size()); end
            n_cmp++; if (first_org_ready !== 1'b1) begin n_bad++; $display("FAIL range%0d_ready: got %b expected 1", k, first_org_ready); end
        end
    endtask

    task automatic test_single();
        logic rs, lr, el;
        send_origin(40, 49, 1'b0, rs, lr, el);
        collect(-1, 20, 1'b0);
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
        n_cmp++; if (got_q[0] !== W_ADDR'(2049)) begin n_bad++; $display("FAIL single_addr: got %0d expected 2049", got_q[0]); end
        n_cmp++; if (got_last_q[0] !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b expected 1", got_last_q[0]); end
        n_cmp++; if (first_org_ready !== 1'b0) begin n_bad++; $display("FAIL single_busy: org_ready %b expected 0", first_org_ready); end
        n_cmp++; if (el !== 1'b0 || err_cnt !== 0) begin n_bad++; $display("FAIL single_err: load %b later %0d expected 0 0", el, err_cnt); end
        send_origin(5, 2, 1'b0, rs, lr, el);
        collect(-1, 20, 1'b0);
        n_cmp++; if (got_q.size() !== 1 || got_q[0] !== W_ADDR'(87)) begin n_bad++; $display("FAIL single_mid: got %0d beats addr %0d expected 1 87", got_q.size(), got_q[0]); end
    endtask

    task automatic test_backpressure();
        logic rs, lr, el;
        build_exp(0, 0, 1'b1);
        send_origin(0, 0, 1'b1, rs, lr, el);
        collect(-1, 5000, 1'b1);
        n_cmp++; if (got_q.size() !== 576) begin n_bad++; $display("FAIL bp_count: got %0d expected 576", got_q.size()); end
        n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL bp_hold: %0d unstable stall cycles expected 0", hold_bad); end
        n_cmp++; if ((stall_cnt > 0) !== 1'b1) begin n_bad++; $display("FAIL bp_stalls: stall cycles %0d expected >0", stall_cnt); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL bp_seq[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic rs, lr, el;
        send_origin(0, 0, 1'b1, rs, lr, el);
        collect(100, 1000, 1'b0);
        n_cmp++; if (got_q.size() !== 100 || addr_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: beats %0d valid %b expected 100 1", got_q.size(), addr_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (addr_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b expected 0", addr_valid); end
        n_cmp++; if (addr_data !== '0 || addr_last !== 1'b0) begin n_bad++; $display("FAIL midrst_out: data %0d last %b expected 0 0", addr_data, addr_last); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, IDLE); end
        @(negedge clk);
        rst = 1'b0;
        build_exp(0, 0, 1'b1);
        send_origin(0, 0, 1'b1, rs, lr, el);
        n_cmp++; if (rs !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b expected 1", rs); end
        collect(-1, 1000, 1'b0);
        n_cmp++; if (got_q[0] !== W_ADDR'(0)) begin n_bad++; $display("FAIL midrst_first: got %0d expected 0", got_q[0]); end
        n_cmp++; if (got_q.size() !== 576) begin n_bad++; $display("FAIL midrst_count: got %0d expected 576", got_q.size()); end
        n_cmp++; if (got_q[$] !== W_ADDR'(966)) begin n_bad++; $display("FAIL midrst_lastaddr: got %0d expected 966", got_q[$]); end
    endtask

    initial begin
        test_reset();
        test_window_origin();
        test_window_corner();
        test_range_err();
        test_single();
        test_backpressure();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
